oam_dma: RTL and testbench

CPU-side sprite DMA engine for the 2A03 bus. It sits directly downstream of the address latch and decoder stage. It watches CPU writes for register $4014 and halts the CPU through RDY. It then copies 256 bytes from CPU page $XX00–$XXFF to the PPU OAM data port $2004 as alternating read/write bus cycles. The block owns the CPU bus only while the transfer runs; the top-level bus mux uses dma_active as its select.

---
 rtl/oam_dma_if.sv | 36 +++
 rtl/oam_dma.sv | 140 ++++++++++++++
 tb/tb_oam_dma.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// oam_dma_if
// Groups the CPU-side bus signals that the sprite DMA engine watches and the
// DMA-side bus signals it drives.
//   cpu_ce     one-clk pulse per CPU cycle
//   cpu_addr   CPU address bus
//   cpu_rw     CPU R/W, 1 = read
//   cpu_dout   CPU write data
//   bus_din    data returned by the bus on DMA read cycles
//   rdy        CPU RDY, 0 halts the CPU
//   dma_active 1 = DMA owns the bus (bus mux select)
//   dma_addr   DMA bus address
//   dma_rw     DMA R/W, 1 = read
//   dma_dout   DMA write data
// The slave modport is the DMA engine; the master modport is the CPU/bus side.
interface oam_dma_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_din;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_dout;

  modport slave (
    input  cpu_ce, cpu_addr, cpu_rw, cpu_dout, bus_din,
    output rdy, dma_active, dma_addr, dma_rw, dma_dout
  );

  modport master (
    output cpu_ce, cpu_addr, cpu_rw, cpu_dout, bus_din,
    input  rdy, dma_active, dma_addr, dma_rw, dma_dout
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma
// Sprite DMA engine for the 2A03 bus. A CPU write to REG_ADDR latches a page
// number and halts the CPU via RDY; the engine then copies page $XX00-$XXFF
// to OAM_PORT as alternating get (read) / put (write) cycles and releases the
// bus when the 256th byte has been written.
// Ports:
//   clk      system clock
//   n_reset  asynchronous active-low reset
//   bus      oam_dma_if.slave: CPU inputs, bus read data, RDY and DMA bus outputs
// Every register advances only on clk edges with bus.cpu_ce = 1, so every
// output holds for the full CPU cycle that follows the edge that set it.
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic     clk,
  input  logic     n_reset,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        par_q, par_d;
  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  latch_q, latch_d;
  logic [7:0]  idx_inc;

  // Wraps at 8 bits so the page number is never incremented.
  assign idx_inc = idx_q + 8'd1;

  // State register. par_q is the parity of the CPU cycle currently running:
  // 0 = get cycle, 1 = put cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      par_q    <= 1'b0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= 16'h0000;
      rw_q     <= 1'b1;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      latch_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      latch_q  <= latch_d;
    end
  end

  // Next state and next registered outputs. Each case computes the outputs
  // for the cycle that the new state represents, so the bus values are ready
  // at the start of that cycle.
  always_comb begin
    state_d  = state_q;
    par_d    = par_q;
    rdy_d    = rdy_q;
    active_d = active_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    page_d   = page_q;
    idx_d    = idx_q;
    latch_d  = latch_q;

    if (bus.cpu_ce) begin
      par_d = ~par_q;
      unique case (state_q)
        IDLE: begin
          if (!bus.cpu_rw && bus.cpu_addr == REG_ADDR) begin
            page_d  = bus.cpu_dout;
            idx_d   = 8'h00;
            rdy_d   = 1'b0;
            state_d = HALT;
          end
        end
        // The CPU only honours RDY on a read, so write cycles keep us here.
        // A put halt cycle means the next cycle is a get: read immediately.
        HALT: begin
          if (bus.cpu_rw) begin
            active_d = 1'b1;
            addr_d   = {page_q, idx_q};
            rw_d     = 1'b1;
            state_d  = par_q ? READ : ALIGN;
          end
        end
        // Dummy read keeps the same address; the returned data is ignored.
        ALIGN: begin
          state_d = READ;
        end
        READ: begin
          latch_d = bus.bus_din;
          addr_d  = OAM_PORT;
          rw_d    = 1'b0;
          state_d = WRITE;
        end
        WRITE: begin
          idx_d = idx_inc;
          rw_d  = 1'b1;
          if (idx_q == 8'hFF) begin
            rdy_d    = 1'b1;
            active_d = 1'b0;
            addr_d   = 16'h0000;
            state_d  = IDLE;
          end else begin
            addr_d  = {page_q, idx_inc};
            state_d = READ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.rdy        = rdy_q;
  assign bus.dma_active = active_q;
  assign bus.dma_addr   = addr_q;
  assign bus.dma_rw     = rw_q;
  assign bus.dma_dout   = latch_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma
// Acts as CPU and memory for oam_dma: drives CPU cycles, serves bus reads from
// a 64 KiB memory image, records every DMA-owned bus cycle, and compares the
// recorded trace and stall length with a transfer model built from memory.
module tb_oam_dma;
  localparam logic [15:0] REG = 16'h4014;
  localparam logic [15:0] OAM = 16'h2004;

  logic clk = 1'b0;
  logic n_reset = 1'b0;

  oam_dma_if bus_if ();

  oam_dma #(.REG_ADDR(REG), .OAM_PORT(OAM)) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int stall = 0;

  logic [7:0]  mem [65536];
  logic [15:0] obs_addr [$];
  logic        obs_rw   [$];
  logic [7:0]  obs_dout [$];

  // Results of the last transfer, inspected by the test tasks.
  int r_first_active;
  int r_timeout;
  int r_rdy_fell;
  int r_end_active;
  int r_gap_bad;
  int r_align;
  int r_aborted;
  int r_reset_bad;

  // One CPU cycle: record what the DMA is doing this cycle, present the
  // CPU inputs, optionally hold cpu_ce low for 'gap' clocks, then pulse cpu_ce.
  task automatic step(input logic [15:0] a, input logic rw, input logic [7:0] d, input int gap);
    logic [15:0] ha;
    logic        hrw;
    logic [7:0]  hd;
    if (bus_if.dma_active === 1'b1) begin
      obs_addr.push_back(bus_if.dma_addr);
      obs_rw.push_back(bus_if.dma_rw);
      obs_dout.push_back(bus_if.dma_dout);
    end
    if (bus_if.rdy !== 1'b1) stall++;
    bus_if.cpu_addr = a;
    bus_if.cpu_rw   = rw;
    bus_if.cpu_dout = d;
    bus_if.bus_din  = mem[bus_if.dma_addr];
    if (gap > 0) begin
      ha  = bus_if.dma_addr;
      hrw = bus_if.dma_rw;
      hd  = bus_if.dma_dout;
      bus_if.bus_din = ~mem[bus_if.dma_addr];
      repeat (gap) @(posedge clk);
      #1;
      if (bus_if.dma_addr !== ha || bus_if.dma_rw !== hrw || bus_if.dma_dout !== hd ||
          bus_if.rdy !== 1'b0 || bus_if.dma_active !== 1'b1)
        r_gap_bad = 1;
      bus_if.bus_din = mem[bus_if.dma_addr];
    end
    @(negedge clk);
    bus_if.cpu_ce = 1'b1;
    @(posedge clk);
    #1;
    bus_if.cpu_ce = 1'b0;
    cyc++;
  endtask

  // Run one complete $4014 transfer. halt_par selects the parity of the halt
  // cycle (-1 = random); extra = CPU write cycles after the trigger; the idx
  // arguments (-1 = unused) place a cpu_ce gap, a stray $4014 write, or a reset
  // at the read of that index.
  task automatic run_transfer(input logic [7:0] page, input int extra, input int halt_par,
                              input int gap_idx, input int trig_idx, input int reset_idx);
    int hp, wp, n;
    logic [15:0] a;
    logic rw;
    logic [7:0] d;
    int gap;
    hp = (halt_par < 0) ? int'($urandom_range(0, 1)) : halt_par;
    wp = (hp + 1 + extra) & 1;
    while ((cyc & 1) != wp) step(16'hC000, 1'b1, 8'h00, 0);
    obs_addr.delete(); obs_rw.delete(); obs_dout.delete();
    stall = 0;
    r_first_active = -1; r_timeout = 0; r_end_active = 0; r_gap_bad = 0;
    r_aborted = 0; r_reset_bad = 0;
    r_align = (hp == 0) ? 1 : 0;
    step(REG, 1'b0, page, 0);
    r_rdy_fell = (bus_if.rdy === 1'b0) ? 1 : 0;
    n = 0;
    forever begin
      if (bus_if.rdy === 1'b1 && stall > 0) begin
        r_end_active = (bus_if.dma_active === 1'b0) ? 0 : 1;
        break;
      end
      if (n >= 800) begin
        r_timeout = 1;
        break;
      end
      if (r_first_active < 0 && bus_if.dma_active === 1'b1) r_first_active = n;
      a = (n < extra) ? 16'h0100 + 16'(n) : 16'hC000;
      rw = (n < extra) ? 1'b0 : 1'b1;
      d = 8'(n);
      gap = 0;
      if (bus_if.dma_active === 1'b1 && bus_if.dma_rw === 1'b1 && n > extra + 1 + r_align) begin
        if (reset_idx >= 0 && bus_if.dma_addr == {page, 8'(reset_idx)}) begin
          #2 n_reset = 1'b0;
          #1;
          if (bus_if.rdy !== 1'b1 || bus_if.dma_active !== 1'b0 || bus_if.dma_rw !== 1'b1 ||
              bus_if.dma_addr !== 16'h0000 || bus_if.dma_dout !== 8'h00)
            r_reset_bad = 1;
          @(negedge clk);
          n_reset = 1'b1;
          cyc = 0;
          r_aborted = 1;
          break;
        end
        if (gap_idx >= 0 && bus_if.dma_addr == {page, 8'(gap_idx)}) gap = 5;
        if (trig_idx >= 0 && bus_if.dma_addr == {page, 8'(trig_idx)}) begin
          a = REG; rw = 1'b0; d = ~page;
        end
      end
      step(a, rw, d, gap);
      n++;
    end
  endtask

  // Reference transfer: optional dummy read of the first byte, then 256
  // read/write pairs. Returns the first trace position that disagrees, or -1.
  function automatic int trace_error(input logic [7:0] page, input int align);
    logic [15:0] ea [$];
    logic        erw [$];
    logic [7:0]  ed [$];
    if (align != 0) begin ea.push_back({page, 8'h00}); erw.push_back(1'b1); ed.push_back(8'h00); end
    for (int i = 0; i < 256; i++) begin
      ea.push_back({page, 8'(i)}); erw.push_back(1'b1); ed.push_back(8'h00);
      ea.push_back(OAM); erw.push_back(1'b0); ed.push_back(mem[{page, 8'(i)}]);
    end
    for (int i = 0; i < ea.size(); i++) begin
      if (i >= obs_addr.size()) return i;
      if (obs_addr[i] !== ea[i] || obs_rw[i] !== erw[i]) return i;
      if (erw[i] == 1'b0 && obs_dout[i] !== ed[i]) return i;
    end
    if (obs_addr.size() != ea.size()) return ea.size();
    return -1;
  endfunction

  task automatic test_reset;
    bus_if.cpu_ce = 1'b0; bus_if.cpu_addr = 16'h0000; bus_if.cpu_rw = 1'b1;
    bus_if.cpu_dout = 8'h00; bus_if.bus_din = 8'h00;
    n_reset = 1'b0;
    #12;
    tests++;
    if (bus_if.rdy !== 1'b1 || bus_if.dma_active !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_ctrl rdy=%b active=%b, need rdy=1 active=0", bus_if.rdy, bus_if.dma_active);
    end
    tests++;
    if (bus_if.dma_addr !== 16'h0000 || bus_if.dma_rw !== 1'b1 || bus_if.dma_dout !== 8'h00) begin
      fails++; $display("[TB] FAIL reset_bus addr=%h rw=%b dout=%h, need 0000/1/00", bus_if.dma_addr, bus_if.dma_rw, bus_if.dma_dout);
    end
    @(negedge clk);
    n_reset = 1'b1;
    cyc = 0;
    step(16'h4015, 1'b0, 8'h12, 0);
    step(REG, 1'b1, 8'h12, 0);
    tests++;
    if (bus_if.rdy !== 1'b1 || bus_if.dma_active !== 1'b0) begin
      fails++; $display("[TB] FAIL idle_non_trigger rdy=%b active=%b, need 1/0", bus_if.rdy, bus_if.dma_active);
    end
  endtask

  // Checks common to a completed transfer.
  task automatic check_transfer(input string name, input logic [7:0] page, input int extra);
    int e, exp_stall;
    exp_stall = 1 + extra + r_align + 512;
    tests++;
    if (r_rdy_fell != 1) begin fails++; $display("[TB] FAIL %s rdy_fall got rdy still high, need 0", name); end
    tests++;
    if (r_timeout != 0) begin fails++; $display("[TB] FAIL %s timeout got no rdy release, need release", name); end
    tests++;
    if (stall != exp_stall) begin fails++; $display("[TB] FAIL %s stall got %0d, need %0d", name, stall, exp_stall); end
    tests++;
    if (r_first_active != extra + 1) begin fails++; $display("[TB] FAIL %s first_active got %0d, need %0d", name, r_first_active, extra + 1); end
    tests++;
    if (r_end_active != 0) begin fails++; $display("[TB] FAIL %s end_active got 1, need 0", name); end
    tests++;
    e = trace_error(page, r_align);
    if (e != -1) begin
      fails++;
      if (e < obs_addr.size())
        $display("[TB] FAIL %s trace at %0d got addr=%h rw=%b dout=%h (len %0d), need model", name, e, obs_addr[e], obs_rw[e], obs_dout[e], obs_addr.size());
      else
        $display("[TB] FAIL %s trace length got %0d, need %0d", name, obs_addr.size(), 512 + r_align);
    end
  endtask

  task automatic test_no_align;
    run_transfer(8'h02, 0, 1, -1, -1, -1);
    check_transfer("no_align", 8'h02, 0);
  endtask

  task automatic test_align;
    run_transfer(8'h02, 0, 0, -1, -1, -1);
    check_transfer("align", 8'h02, 0);
  endtask

  task automatic test_halt_writes;
    run_transfer(8'h02, 2, -1, -1, -1, -1);
    check_transfer("halt_writes", 8'h02, 2);
  endtask

  task automatic test_page_ff;
    run_transfer(8'hFF, 0, -1, -1, -1, -1);
    check_transfer("page_ff", 8'hFF, 0);
  endtask

  task automatic test_reset_mid;
    run_transfer(8'h80, 0, -1, -1, -1, 8'h37);
    tests++;
    if (r_aborted != 1) begin fails++; $display("[TB] FAIL reset_mid reached got no idx 37 read, need one"); end
    tests++;
    if (r_reset_bad != 0) begin
      fails++; $display("[TB] FAIL reset_mid outputs rdy=%b active=%b rw=%b addr=%h, need 1/0/1/0000", bus_if.rdy, bus_if.dma_active, bus_if.dma_rw, bus_if.dma_addr);
    end
    run_transfer(8'h02, 0, -1, -1, -1, -1);
    check_transfer("after_reset", 8'h02, 0);
  endtask

  task automatic test_ce_gap_retrigger;
    run_transfer(8'h41, 0, -1, 8'h10, 8'h20, -1);
    check_transfer("gap_retrig", 8'h41, 0);
    tests++;
    if (r_gap_bad != 0) begin fails++; $display("[TB] FAIL ce_gap_hold got output change while cpu_ce low, need none"); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] p;
    int ex;
    for (int k = 0; k < 3; k++) begin
      p  = 8'($urandom);
      ex = int'($urandom_range(0, 3));
      run_transfer(p, ex, -1, int'($urandom_range(1, 254)), -1, -1);
      check_transfer($sformatf("b2b%0d", k), p, ex);
      tests++;
      if (r_gap_bad != 0) begin fails++; $display("[TB] FAIL b2b%0d gap_hold got output change, need none", k); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_no_align();
    test_align();
    test_halt_writes();
    test_page_ff();
    test_reset_mid();
    test_ce_gap_retrigger();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
